mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single data-memory bus (DataMem, including its memory-mapped BCD display registers) between the pipelined CPU and a secondary DMA/loader requester.
- The CPU has priority. A starvation counter guarantees the DMA requester one access after at most MAX_WAIT contended cycles.
- Sits between the CPU's MemBus port and DataMem in the top level. It drives cpu_stall into the CPU's hazard unit.

Parameters:
- MAX_WAIT, 4: cycles dma_req may be blocked by CPU traffic before the DMA access is forced; legal range 1..255.
- CNT_W, 8: width of the starvation counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_read  in  1  CPU load request this cycle.
- cpu_write  in  1  CPU store request this cycle.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU store data.
- cpu_rdata  out  32  load data to CPU.
- cpu_stall  out  1  CPU access not serviced this cycle; CPU holds its request.
- dma_req  in  1  DMA request; held with dma_we/dma_addr/dma_wdata stable until dma_ack.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  32  DMA byte address.
- dma_wdata  in  32  DMA write data.
- dma_rdata  out  32  registered DMA read data; valid while dma_ack = 1.
- dma_ack  out  1  one-cycle completion pulse.
- mem_read  out  1  to DataMem MemRead.
- mem_write  out  1  to DataMem MemWrite.
- mem_addr  out  32  to DataMem Address.
- mem_wdata  out  32  to DataMem Write_data.
- mem_rdata  in  32  from DataMem Read_data; combinational, same-cycle.

Behaviour:
- cpu_active = cpu_read | cpu_write. The CPU driving both read and write at once is illegal; the arbiter passes both through unchanged.
- The FSM has two states: ARB and ACK. Reset value is ARB, with wait_cnt = 0, dma_ack = 0 and dma_rdata = 0.
- While reset = 1:
  - mem_read = mem_write = 0 and cpu_stall = 0.
  - mem_addr = cpu_addr and mem_wdata = cpu_wdata.
- grant_dma (combinational) = (state == ARB) & dma_req & (~cpu_active | wait_cnt == MAX_WAIT).
- Bus mux:
  - When grant_dma = 1: mem_addr = dma_addr, mem_wdata = dma_wdata, mem_write = dma_we, mem_read = ~dma_we.
  - Otherwise the CPU signals pass straight through.
- cpu_stall = grant_dma & cpu_active.
- cpu_rdata = mem_rdata at all times; the CPU ignores it when stalled.
- ARB state:
  - If grant_dma: next state ACK. At the edge, dma_rdata <= mem_rdata (read only; a write leaves dma_rdata unchanged), dma_ack <= 1, wait_cnt <= 0.
  - Else if dma_req & cpu_active: wait_cnt <= wait_cnt + 1, saturating at MAX_WAIT.
  - Else if ~dma_req: wait_cnt <= 0.
- ACK state:
  - dma_ack = 1 for exactly this cycle. The CPU owns the bus and no DMA grant occurs even if dma_req is still high.
  - Next state ARB, dma_ack <= 0, wait_cnt <= 0.
- DMA latency:
  - Bus access happens in the grant cycle; ack follows 1 cycle later.
  - Minimum DMA issue interval is 2 cycles.
  - Worst-case request-to-grant is MAX_WAIT + 1 cycles under continuous CPU traffic.
- CPU stall bound: at most 1 stalled cycle per DMA access. Stalls are never back-to-back from the same DMA request stream, because ACK always gives the CPU the bus.
- If dma_req drops before grant (protocol violation): no grant occurs, wait_cnt clears, and no ack is issued.
- Reset mid-operation: a pending ack is cancelled (dma_ack = 0 on the next cycle) and the FSM returns to ARB. Any DMA access in the reset cycle is not performed.
- The arbiter does not align or decode addresses; DataMem handles peripheral decoding.

Test Plan:
- Reset, then idle CPU, dma_req = 1, dma_we = 0, dma_addr = 0x10, mem word 0x10 = 0xCAFEBABE:
  - mem_read = 1 and mem_addr = 0x10 in the same cycle.
  - Next cycle: dma_ack = 1, dma_rdata = 0xCAFEBABE.
  - cpu_stall stays 0 throughout.
- CPU store every cycle to 0x20; DMA write 0x55 to 0x30 held pending, MAX_WAIT = 4:
  - CPU served for 4 cycles with cpu_stall = 0.
  - 5th cycle: mem_addr = 0x30, mem_write = 1, cpu_stall = 1.
  - 6th cycle: dma_ack = 1, CPU address back on the bus, cpu_stall = 0.
- DMA holds dma_req high through the ack cycle with a second request:
  - No grant in the ACK cycle.
  - Second access granted the following cycle if the CPU is idle.
  - Exactly 2 ack pulses in total.
- CPU load from 0x40 = 0x12345678 with no DMA traffic: cpu_rdata = 0x12345678 in the same cycle, cpu_stall = 0, dma_ack = 0.
- Assert reset in the cycle after a DMA grant: dma_ack = 0 and state = ARB on the next cycle; mem_read = mem_write = 0 during reset.
- dma_req pulsed for 2 cycles under CPU traffic, then dropped: no dma_ack, and wait_cnt returns to 0 (the next DMA request again waits the full MAX_WAIT).

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the DataMem bus between the CPU (priority)
// and a DMA/loader requester, with a starvation counter for the DMA.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_read/write/addr/wdata  CPU MemBus request
//   cpu_rdata, cpu_stall       CPU load data, stall to hazard unit
//   dma_req/we/addr/wdata      DMA request, held until dma_ack
//   dma_rdata, dma_ack         registered DMA read data, done pulse
//   mem_read/write/addr/wdata  to DataMem
//   mem_rdata                  from DataMem (combinational)
module mem_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    ARB = 1'b0,
    ACK = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MaxWait = CNT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              dma_ack_q, dma_ack_d;
  logic [31:0]       dma_rdata_q, dma_rdata_d;

  logic cpu_active;
  logic starved;
  logic grant_dma;

  assign cpu_active = cpu_read | cpu_write;
  assign starved    = (wait_cnt_q == MaxWait);

  // No DMA access may reach memory during the reset cycle.
  assign grant_dma = ~reset
                   & (state_q == ARB)
                   & dma_req
                   & (~cpu_active | starved);

  assign cpu_stall = grant_dma & cpu_active;
  assign cpu_rdata = mem_rdata;
  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;

  // Bus mux: CPU passes through unless the DMA is granted.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_read  = cpu_read & ~reset;
    mem_write = cpu_write & ~reset;
    if (grant_dma) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_write = dma_we;
      mem_read  = ~dma_we;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dma_ack_d   = 1'b0;
    dma_rdata_d = dma_rdata_q;
    unique case (state_q)
      ARB: begin
        if (grant_dma) begin
          state_d    = ACK;
          dma_ack_d  = 1'b1;
          wait_cnt_d = '0;
          if (!dma_we) begin
            dma_rdata_d = mem_rdata;
          end
        end else if (dma_req && cpu_active) begin
          // Saturate so the forced grant stays pending.
          if (!starved) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else if (!dma_req) begin
          wait_cnt_d = '0;
        end
      end
      ACK: begin
        // The CPU always owns the bus in the ack cycle.
        state_d    = ARB;
        dma_ack_d  = 1'b0;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = ARB;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      wait_cnt_q  <= '0;
      dma_ack_q   <= 1'b0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      dma_ack_q   <= dma_ack_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of the memory bus arbiter
// against a small word-addressed DataMem model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_WAIT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (dma_ack) ack_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h04] = 32'hCAFEBABE;
    mem[8'h10] = 32'h12345678;

    reset = 1'b1;
    cpu_read = 0; cpu_write = 1; cpu_addr = 32'h44;
    cpu_wdata = 32'h1; dma_req = 1; dma_we = 0;
    dma_addr = 32'h10; dma_wdata = 0;
    cyc(); cyc();
    settle();
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_addr", mem_addr, 32'h44);
    chk("rst_ack", {31'd0, dma_ack}, 32'd0);
    chk("rst_rdata", dma_rdata, 32'd0);

    cyc();
    reset = 0; cpu_write = 0; dma_req = 0;
    cpu_addr = 32'h0;
    cyc();

    // DMA read with idle CPU.
    dma_req = 1; dma_we = 0; dma_addr = 32'h10;
    settle();
    chk("t1_mem_read", {31'd0, mem_read}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_stall", {31'd0, cpu_stall}, 32'd0);
    cyc();
    dma_req = 0;
    settle();
    chk("t1_ack", {31'd0, dma_ack}, 32'd1);
    chk("t1_rdata", dma_rdata, 32'hCAFEBABE);
    chk("t1_stall2", {31'd0, cpu_stall}, 32'd0);
    cyc();
    settle();
    chk("t1_ack_off", {31'd0, dma_ack}, 32'd0);

    // CPU load, no DMA.
    cpu_read = 1; cpu_addr = 32'h40;
    settle();
    chk("t4_rdata", cpu_rdata, 32'h12345678);
    chk("t4_stall", {31'd0, cpu_stall}, 32'd0);
    chk("t4_ack", {31'd0, dma_ack}, 32'd0);
    chk("t4_mem_read", {31'd0, mem_read}, 32'd1);
    cyc();
    cpu_read = 0;

    // Starvation: CPU stores every cycle, DMA write pending.
    cpu_write = 1; cpu_addr = 32'h20;
    dma_req = 1; dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'h55;
    for (int i = 0; i < 4; i++) begin
      cpu_wdata = 32'hAAAA0000 + i;
      settle();
      chk("t2_cpu_stall", {31'd0, cpu_stall}, 32'd0);
      chk("t2_cpu_addr", mem_addr, 32'h20);
      cyc();
    end
    settle();
    chk("t2_dma_addr", mem_addr, 32'h30);
    chk("t2_dma_write", {31'd0, mem_write}, 32'd1);
    chk("t2_dma_wdata", mem_wdata, 32'h55);
    chk("t2_stall", {31'd0, cpu_stall}, 32'd1);
    cyc();
    dma_req = 0;
    settle();
    chk("t2_ack", {31'd0, dma_ack}, 32'd1);
    chk("t2_back_addr", mem_addr, 32'h20);
    chk("t2_unstall", {31'd0, cpu_stall}, 32'd0);
    chk("t2_rdata_kept", dma_rdata, 32'hCAFEBABE);
    cyc();
    cpu_write = 0;
    settle();
    chk("t2_mem_word", mem[8'h0C], 32'h55);
    cyc();

    // Back-to-back requests with dma_req held through ack.
    ack_cnt = 0;
    cpu_addr = 32'h0;
    dma_req = 1; dma_we = 0; dma_addr = 32'h10;
    settle();
    chk("t3_g1_read", {31'd0, mem_read}, 32'd1);
    chk("t3_g1_addr", mem_addr, 32'h10);
    cyc();
    dma_addr = 32'h40;
    settle();
    chk("t3_ack1", {31'd0, dma_ack}, 32'd1);
    chk("t3_rdata1", dma_rdata, 32'hCAFEBABE);
    chk("t3_no_grant", {31'd0, mem_read}, 32'd0);
    chk("t3_ack_addr", mem_addr, 32'h0);
    cyc();
    settle();
    chk("t3_g2_read", {31'd0, mem_read}, 32'd1);
    chk("t3_g2_addr", mem_addr, 32'h40);
    chk("t3_g2_ack", {31'd0, dma_ack}, 32'd0);
    cyc();
    dma_req = 0;
    settle();
    chk("t3_ack2", {31'd0, dma_ack}, 32'd1);
    chk("t3_rdata2", dma_rdata, 32'h12345678);
    cyc(); cyc();
    chk("t3_ack_count", ack_cnt, 32'd2);

    // Reset in the cycle after a grant.
    dma_req = 1; dma_we = 0; dma_addr = 32'h10;
    settle();
    chk("t5_grant", {31'd0, mem_read}, 32'd1);
    cyc();
    reset = 1; cpu_read = 1; cpu_addr = 32'h40;
    settle();
    chk("t5_rst_read", {31'd0, mem_read}, 32'd0);
    chk("t5_rst_write", {31'd0, mem_write}, 32'd0);
    chk("t5_rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("t5_rst_addr", mem_addr, 32'h40);
    cyc();
    reset = 0; cpu_read = 0; cpu_addr = 32'h0;
    dma_req = 0;
    settle();
    chk("t5_ack_cancel", {31'd0, dma_ack}, 32'd0);
    chk("t5_rdata_clr", dma_rdata, 32'd0);
    dma_req = 1;
    settle();
    chk("t5_arb_grant", {31'd0, mem_read}, 32'd1);
    cyc();
    dma_req = 0;
    settle();
    chk("t5_ack", {31'd0, dma_ack}, 32'd1);
    cyc();

    // Aborted request clears the wait counter.
    cpu_write = 1; cpu_addr = 32'h20; cpu_wdata = 32'h9;
    dma_req = 1; dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'h77;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("t6_pulse_stall", {31'd0, cpu_stall}, 32'd0);
      cyc();
    end
    dma_req = 0;
    settle();
    chk("t6_no_ack_a", {31'd0, dma_ack}, 32'd0);
    cyc();
    settle();
    chk("t6_no_ack_b", {31'd0, dma_ack}, 32'd0);
    dma_req = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t6_wait_stall", {31'd0, cpu_stall}, 32'd0);
      cyc();
    end
    settle();
    chk("t6_forced_stall", {31'd0, cpu_stall}, 32'd1);
    chk("t6_forced_addr", mem_addr, 32'h30);
    cyc();
    dma_req = 0;
    settle();
    chk("t6_ack", {31'd0, dma_ack}, 32'd1);
    cyc();
    cpu_write = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
